// File: rtl/if_id_if.sv
// Fetch-to-decode bus: fetch pushes into the buffer, decode pops its head.
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1; the producer holds its data stable while valid is up.
interface if_id_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_PC4;
  logic [31:0] in_Ins;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_PC4;
  logic [31:0] out_Ins;

  modport master (
    output in_valid, in_PC4, in_Ins, flush, out_ready,
    input  in_ready, out_valid, out_PC4, out_Ins
  );

  modport slave (
    input  in_valid, in_PC4, in_Ins, flush, out_ready,
    output in_ready, out_valid, out_PC4, out_Ins
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register built as a 2-entry skid buffer with a registered in_ready.
// The buffer supports flush and counts decode-side stall cycles.
module if_id_buffer #(
  parameter logic [31:0] NOP_INS = 32'h0000_0000,
  parameter int          CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  if_id_if.slave           bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The state value is the occupancy, so occupancy doubles as the FSM debug view.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             in_ready_q;
  logic [31:0]      head_pc_q, head_ins_q;
  logic [31:0]      tail_pc_q, tail_ins_q;
  logic [CNT_W-1:0] stall_q;

  logic push, pop;
  logic load_head_in, load_tail_in, head_from_tail;

  always_comb begin
    push           = bus.in_valid & in_ready_q;
    pop            = (state_q != S_EMPTY) & bus.out_ready;
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_tail_in   = 1'b0;
    head_from_tail = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d      = S_ONE;
          load_head_in = 1'b1;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_d      = S_FULL;
          load_tail_in = 1'b1;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d        = S_ONE;
          head_from_tail = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (bus.flush) begin
      state_d        = S_EMPTY;
      load_head_in   = 1'b0;
      load_tail_in   = 1'b0;
      head_from_tail = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      head_pc_q  <= 32'h0;
      head_ins_q <= NOP_INS;
      tail_pc_q  <= 32'h0;
      tail_ins_q <= NOP_INS;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_FULL);

      // Going empty forces the NOP into HEAD; the PC4 deliberately keeps its last value.
      if (load_head_in) begin
        head_pc_q  <= bus.in_PC4;
        head_ins_q <= bus.in_Ins;
      end else if (head_from_tail) begin
        head_pc_q  <= tail_pc_q;
        head_ins_q <= tail_ins_q;
      end else if (state_d == S_EMPTY) begin
        head_ins_q <= NOP_INS;
      end

      if (load_tail_in) begin
        tail_pc_q  <= bus.in_PC4;
        tail_ins_q <= bus.in_Ins;
      end

      if ((state_q != S_EMPTY) && !bus.out_ready && !bus.flush && (stall_q != CNT_MAX))
        stall_q <= stall_q + CNT_ONE;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.out_PC4   = head_pc_q;
  assign bus.out_Ins   = head_ins_q;
  assign occupancy     = state_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomised and directed bench for if_id_buffer: a FIFO reference model feeds a scoreboard
// queue that a negedge monitor drains; a second CNT_W=4 instance covers counter saturation.
module tb_if_id_buffer;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK;
  logic        RST;
  logic [1:0]  occupancy, sat_occupancy;
  logic [15:0] stall_cnt;
  logic [3:0]  sat_stall_cnt;

  if_id_if bus ();
  if_id_if sbus ();

  if_id_buffer #(.NOP_INS(NOP), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  if_id_buffer #(.NOP_INS(NOP), .CNT_W(4)) u_sat (
    .CLK(CLK), .RST(RST), .bus(sbus), .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: held entries as a count, accepted entries in the scoreboard queue
  logic [63:0] exp_q[$];
  int          mcnt  = 0;
  int          mstall = 0;

  always @(posedge CLK) begin
    if (RST) begin
      mcnt   = 0;
      mstall = 0;
      exp_q.delete();
    end else begin
      automatic bit m_push = bus.in_valid && (mcnt < 2);
      automatic bit m_pop  = (mcnt > 0) && bus.out_ready;
      if ((mcnt > 0) && !bus.out_ready && !bus.flush && (mstall < 65535)) mstall++;
      if (bus.flush) begin
        mcnt = 0;
        exp_q.delete();
      end else begin
        if (m_push) exp_q.push_back({bus.in_PC4, bus.in_Ins});
        mcnt = mcnt + int'(m_push) - int'(m_pop);
      end
    end
  end

  // monitor: compares status every cycle and pops the scoreboard on each consumed head
  always @(negedge CLK) begin
    check("out_valid", 64'(bus.out_valid), 64'(mcnt != 0));
    check("occupancy", 64'(occupancy), 64'(mcnt));
    check("in_ready", 64'(bus.in_ready), 64'(mcnt < 2));
    check("stall_cnt", 64'(stall_cnt), 64'(mstall));
    if (mcnt == 0) check("out_Ins_empty", 64'(bus.out_Ins), 64'(NOP));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pop_unexpected: got pc=%0h ins=%0h expected no entry at %0t",
                 bus.out_PC4, bus.out_Ins, $time);
      end else begin
        automatic logic [63:0] e = exp_q.pop_front();
        check("head_pc4", 64'(bus.out_PC4), 64'(e[63:32]));
        check("head_ins", 64'(bus.out_Ins), 64'(e[31:0]));
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.in_valid = v;
    bus.in_PC4   = pc;
    bus.in_Ins   = ins;
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.in_PC4    = 32'h0;
    sbus.in_Ins    = 32'h0;
    sbus.flush     = 1'b0;
    sbus.out_ready = 1'b0;

    // reset then idle
    cyc(); cyc();
    RST = 1'b0;
    cyc();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_ins", 64'(bus.out_Ins), 64'(NOP));
    check("rst_out_pc4", 64'(bus.out_PC4), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);

    // streaming at full rate
    bus.out_ready = 1'b1;
    drive(1'b1, 32'd4,  32'h2008_0005); cyc();
    check("stream_ins0", 64'(bus.out_Ins), 64'h2008_0005);
    drive(1'b1, 32'd8,  32'h2009_0003); cyc();
    check("stream_ins1", 64'(bus.out_Ins), 64'h2009_0003);
    drive(1'b1, 32'd12, 32'h0109_5020); cyc();
    check("stream_ins2", 64'(bus.out_Ins), 64'h0109_5020);
    check("stream_pc2", 64'(bus.out_PC4), 64'd12);
    drive(1'b0, 32'd0, 32'h0); cyc(); cyc();

    // backpressure and skid
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd16, 32'h8C01_0000); cyc();
    drive(1'b1, 32'd20, 32'hAC02_0004); cyc();
    check("skid_full", 64'(occupancy), 64'd2);
    check("skid_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'd24, 32'h0000_0C0C); cyc(); cyc(); cyc();
    check("skid_head", 64'(bus.out_Ins), 64'h8C01_0000);
    check("skid_stall", 64'(stall_cnt), 64'd4);
    bus.out_ready = 1'b1;
    cyc(); cyc();
    drive(1'b0, 32'd0, 32'h0);
    cyc(); cyc(); cyc();

    // flush while full with a simultaneous push
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd28, 32'h1111_0001); cyc();
    drive(1'b1, 32'd32, 32'h1111_0002); cyc();
    drive(1'b1, 32'd36, 32'h1000_FFFF);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 32'h0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ins", 64'(bus.out_Ins), 64'(NOP));
    bus.out_ready = 1'b1;
    cyc(); cyc();

    // asynchronous reset between edges while full
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd40, 32'h2222_0001); cyc();
    drive(1'b1, 32'd44, 32'h2222_0002); cyc();
    drive(1'b0, 32'd0, 32'h0);
    cyc();
    RST = 1'b1;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_ins", 64'(bus.out_Ins), 64'(NOP));
    check("arst_pc4", 64'(bus.out_PC4), 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_ready", 64'(bus.in_ready), 64'd1);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    exp_q.delete();
    mcnt   = 0;
    mstall = 0;
    cyc();
    RST = 1'b0;
    bus.out_ready = 1'b1;
    cyc(); cyc(); cyc();

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      cyc();
    end
    bus.flush     = 1'b0;
    drive(1'b0, 32'd0, 32'h0);
    bus.out_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // stall counter saturation on the 4-bit instance
    sbus.in_valid = 1'b1;
    sbus.in_PC4   = 32'd100;
    sbus.in_Ins   = 32'h3333_0001;
    cyc();
    sbus.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("sat_stall", 64'(sat_stall_cnt), 64'((k < 15) ? k : 15));
    end
    check("sat_hold_ins", 64'(sbus.out_Ins), 64'h3333_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
